// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: four CPOL/CPHA modes, MSB/LSB-first,
// sclk half-period of CLK_DIV clk cycles, NUM_CS active-low chip selects.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; sclk follows the cpol input
// S_SETUP    | chip select asserted for CLK_DIV cycles before the first edge
// S_TRANSFER | 2*DATA_WIDTH sclk edges, one every CLK_DIV cycles
// S_HOLD     | chip select held for CLK_DIV cycles after the last edge
// S_DONE     | one-cycle completion pulse; data_out updated on entry
module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int NUM_CS     = 1,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  buzy,
    output logic                  done,
    output logic [NUM_CS-1:0]     cs,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int CNT_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LOAD = EDGE_W'(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_TRANSFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [EDGE_W-1:0]     edge_left;
    logic                  cpol_q, cpha_q, lsb_q;
    logic [CS_W-1:0]       sel_q;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
    logic                  half_end;
    logic                  leading;
    logic                  last_edge;

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                        input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                       input logic lsb, input logic b);
        return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
    endfunction

    assign half_end  = (cnt == '0);
    // edge_left starts even, so an even remaining count marks a leading edge
    assign leading   = ~edge_left[0];
    assign last_edge = (edge_left == EDGE_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode plus status and chip-select outputs
    always_comb begin
        state_nxt = state;
        buzy      = 1'b0;
        done      = 1'b0;
        cs        = '1;
        case (state)
            S_IDLE:     if (start) state_nxt = S_SETUP;
            S_SETUP:    begin
                buzy = 1'b1;
                if (half_end) state_nxt = S_TRANSFER;
            end
            S_TRANSFER: begin
                buzy = 1'b1;
                if (half_end && last_edge) state_nxt = S_HOLD;
            end
            S_HOLD:     begin
                buzy = 1'b1;
                if (half_end) state_nxt = S_DONE;
            end
            S_DONE:     begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
        // an out-of-range cs_sel matches no line, so all selects stay high
        for (int i = 0; i < NUM_CS; i++) begin
            if (buzy && sel_q == CS_W'(i)) cs[i] = 1'b0;
        end
    end

    // Datapath: timers, sclk generation, shift registers and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            edge_left <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sel_q     <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            data_out  <= '0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    sclk <= cpol;
                    mosi <= 1'b0;
                    if (start) begin
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        lsb_q  <= lsb_first;
                        sel_q  <= cs_sel;
                        cnt    <= CNT_LOAD;
                        rx_sr  <= '0;
                        // cpha=0 drives the first bit during setup; cpha=1 waits for the first edge
                        if (cpha) begin
                            tx_sr <= data_in;
                        end else begin
                            tx_sr <= shift_out(data_in, lsb_first);
                            mosi  <= head_bit(data_in, lsb_first);
                        end
                    end
                end
                S_SETUP: begin
                    if (half_end) begin
                        cnt       <= CNT_LOAD;
                        edge_left <= EDGE_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_TRANSFER: begin
                    if (half_end) begin
                        cnt       <= CNT_LOAD;
                        sclk      <= ~sclk;
                        edge_left <= edge_left - 1'b1;
                        if (cpha_q ? leading : (!leading && !last_edge)) begin
                            mosi  <= head_bit(tx_sr, lsb_q);
                            tx_sr <= shift_out(tx_sr, lsb_q);
                        end
                        if (cpha_q ? !leading : leading) begin
                            rx_sr <= shift_in(rx_sr, lsb_q, miso);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    sclk <= cpol_q;
                    if (half_end) begin
                        data_out <= rx_sr;
                        mosi     <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: mosi <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master that serialises a DATA_WIDTH-bit word on mosi and captures a word from miso in one full-duplex transfer. It supports all four SPI modes (CPOL/CPHA), MSB- or LSB-first ordering, a programmable sclk divider and NUM_CS independent active-low chip selects. It is the successor to the fixed 8-bit mode-0 SPI master. It moves key and state blocks between the AES core and external devices.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
NUM_CS, 1, number of chip-select lines (>=1)
CS_W, max(1,clog2(NUM_CS)), derived width of cs_sel (localparam)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a transfer; sampled in IDLE only
cpol  in  1  clock polarity; latched at accept
cpha  in  1  clock phase; latched at accept
lsb_first  in  1  1 = LSB first; latched at accept
cs_sel  in  CS_W  target slave index; latched at accept
data_in  in  DATA_WIDTH  word to transmit; latched at accept
data_out  out  DATA_WIDTH  last received word
buzy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
cs  out  NUM_CS  active-low chip selects
sclk  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in

Behaviour:
- Reset (reset=0, async): state IDLE; buzy=0, done=0, data_out=0, cs=all 1, sclk=0, mosi=0. All counters and shift registers are cleared. Reset mid-transfer aborts the transfer immediately. No done pulse follows. Transfers may start again in the first IDLE cycle after release.
- IDLE: sclk is registered from the cpol input every cycle. mosi=0. An accept occurs when start=1 on a clk edge in IDLE. That edge latches the mode, cs_sel and data_in. The block enters SETUP and buzy=1 from the next cycle.
- SETUP, CLK_DIV cycles: cs[cs_sel]=0. If cs_sel>=NUM_CS, all cs stay 1 and the transfer still runs. With cpha=0, mosi presents the first bit.
- TRANSFER, 2*DATA_WIDTH*CLK_DIV cycles: sclk toggles every CLK_DIV cycles, giving 2*DATA_WIDTH edges.
  - cpha=0: miso is sampled on leading (odd) edges. mosi shifts to the next bit on trailing edges, except the final trailing edge.
  - cpha=1: mosi shifts on leading edges, starting with the first bit on the first leading edge. miso is sampled on trailing edges.
  - Bit order: MSB first if lsb_first=0, otherwise LSB first. The same order applies to the receive assembly, so the first received bit lands at bit DATA_WIDTH-1 (MSB-first) or bit 0 (LSB-first).
  - sclk returns to the latched cpol level after the last edge.
- HOLD, CLK_DIV cycles: cs stays asserted, sclk=cpol, mosi holds the last bit.
- DONE, 1 cycle: buzy=0, done=1, cs=all 1, mosi=0. data_out is loaded from the receive register on the edge entering DONE. data_out holds until the next DONE. The block then returns to IDLE.
- Latency: buzy is high for exactly (2*DATA_WIDTH+2)*CLK_DIV cycles. done rises on the next edge. For defaults, accept at edge N gives buzy over N+1..N+36 and done at N+37.
- start while buzy=1 or done=1 is ignored and not queued. Input changes after accept do not affect the transfer in flight.
- Back-to-back: start held high re-accepts in the first IDLE cycle after DONE, giving a minimum gap of one IDLE cycle.
- Only one cs bit is ever low at a time, and only during SETUP, TRANSFER and HOLD.

Test Plan:
- Defaults, mosi looped to miso, mode 0, data_in=0xA5, 1-cycle start -> buzy high for 36 cycles, done pulse at accept+37, data_out=0xA5, eight sclk rising edges, idle sclk=0.
- Mode 3 (cpol=1, cpha=1), miso driven by a slave model returning 0x3C, data_in=0xC3 -> sclk idles at 1, slave captures 0xC3, data_out=0x3C.
- lsb_first=1, mode 0, data_in=0x01, loopback -> mosi=1 on the first bit only, data_out=0x01. With miso held at 1 for the first bit only -> data_out=0x01.
- NUM_CS=4, cs_sel=2 -> cs=4'b1011 during the transfer and 4'b1111 otherwise. cs_sel=3 -> 4'b0111.
- start pulsed again mid-transfer, then reset=0 at accept+10 -> the second start is ignored. After reset: cs=all 1, buzy=0, sclk=0, no done pulse, data_out=0.
- DATA_WIDTH=16, CLK_DIV=1, loopback of 0xBEEF, mode 1 -> buzy for 34 cycles, data_out=0xBEEF.
